// File: rtl/board_pkg.sv
// Shared types and screen constants for the board cursor controller.
package board_pkg;

  localparam int SCR_W = 11;
  localparam int SCR_H = 10;

  typedef enum logic [2:0] {
    NONE,
    UP,
    DOWN,
    LEFT,
    RIGHT
  } dir_t;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } cur_state_t;

  // A direction is valid only when exactly one button is pressed.
  function automatic dir_t decode_dir(input logic up, input logic down,
                                      input logic left, input logic right);
    dir_t d;
    case ({up, down, left, right})
      4'b1000: d = UP;
      4'b0100: d = DOWN;
      4'b0010: d = LEFT;
      4'b0001: d = RIGHT;
      default: d = NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector for a level input already in the clk domain.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic prev_q, prev_d;

  // Next value of the history bit is simply the current input level.
  always_comb begin
    prev_d = d;
  end

  // History register holding the previous cycle's input level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= prev_d;
  end

  assign rise = d & ~prev_q;

endmodule

// File: rtl/board_cursor_ctrl.sv
// Board cursor controller: frame-synchronous cell moves with autorepeat,
// edge clamping, pixel position for the sprite compositor and a select handshake.
module board_cursor_ctrl
  import board_pkg::*;
#(
  parameter int COLS         = 8,
  parameter int ROWS         = 8,
  parameter int CELL_W       = 64,
  parameter int CELL_H       = 60,
  parameter int ORIGIN_X     = 64,
  parameter int ORIGIN_Y     = 0,
  parameter int REPEAT_DELAY = 30,
  parameter int REPEAT_RATE  = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame_tick,
  input  logic                      en,
  input  logic                      btn_up,
  input  logic                      btn_down,
  input  logic                      btn_left,
  input  logic                      btn_right,
  input  logic                      btn_sel,
  input  logic                      sel_ready,
  output logic [10:0]               cur_pos_x,
  output logic [9:0]                cur_pos_y,
  output logic [10:0]               cur_width_x,
  output logic [9:0]                cur_width_y,
  output logic [$clog2(COLS)-1:0]   cur_col,
  output logic [$clog2(ROWS)-1:0]   cur_row,
  output logic                      sel_valid,
  output logic [$clog2(COLS)-1:0]   sel_col,
  output logic [$clog2(ROWS)-1:0]   sel_row
);

  localparam int COL_W   = $clog2(COLS);
  localparam int ROW_W   = $clog2(ROWS);
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  if (ORIGIN_X + COLS * CELL_W > 2048) begin : g_x_range_err
    $error("board_cursor_ctrl: board does not fit horizontally");
  end
  if (ORIGIN_Y + ROWS * CELL_H > 1024) begin : g_y_range_err
    $error("board_cursor_ctrl: board does not fit vertically");
  end

  cur_state_t              state_q, state_d;
  dir_t                    dir_q, dir_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [SCR_W-1:0]        pos_x_q, pos_x_d;
  logic [SCR_H-1:0]        pos_y_q, pos_y_d;
  logic                    sel_valid_q, sel_valid_d;
  logic [COL_W-1:0]        sel_col_q, sel_col_d;
  logic [ROW_W-1:0]        sel_row_q, sel_row_d;
  logic                    sel_rise;
  logic                    move;
  dir_t                    dir_in;

  rise_detect u_sel_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_sel),
    .rise  (sel_rise)
  );

  assign dir_in = decode_dir(btn_up, btn_down, btn_left, btn_right);

  // Hold/autorepeat sequencing; only frame ticks advance it, disable or a pending select park it in IDLE.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    move    = 1'b0;
    if (!en || sel_valid_q) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (frame_tick) begin
      case (state_q)
        IDLE: begin
          if (dir_in != NONE) begin
            move    = 1'b1;
            dir_d   = dir_in;
            cnt_d   = '0;
            state_d = DELAY;
          end
        end
        DELAY, REPEAT: begin
          if (dir_in != dir_q) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == ((state_q == DELAY) ? CNT_W'(REPEAT_DELAY - 1)
                                                    : CNT_W'(REPEAT_RATE - 1))) begin
            move    = 1'b1;
            cnt_d   = '0;
            state_d = REPEAT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Apply a move with edge clamping, then derive pixel position from the new cell.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (move) begin
      case (dir_in)
        UP:      if (row_q != '0)                row_d = row_q - ROW_W'(1);
        DOWN:    if (row_q != ROW_W'(ROWS - 1))  row_d = row_q + ROW_W'(1);
        LEFT:    if (col_q != '0)                col_d = col_q - COL_W'(1);
        RIGHT:   if (col_q != COL_W'(COLS - 1))  col_d = col_q + COL_W'(1);
        default: ;
      endcase
    end
    pos_x_d = SCR_W'(ORIGIN_X) + SCR_W'(col_d) * SCR_W'(CELL_W);
    pos_y_d = SCR_H'(ORIGIN_Y) + SCR_H'(row_d) * SCR_H'(CELL_H);
  end

  // Select handshake; a clear always takes priority and edges while pending are dropped.
  always_comb begin
    sel_valid_d = sel_valid_q;
    sel_col_d   = sel_col_q;
    sel_row_d   = sel_row_q;
    if (sel_valid_q) begin
      if (sel_ready) sel_valid_d = 1'b0;
    end else if (en && sel_rise) begin
      sel_valid_d = 1'b1;
      sel_col_d   = col_q;
      sel_row_d   = row_q;
    end
  end

  // State, cursor and selection registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dir_q       <= NONE;
      cnt_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      pos_x_q     <= SCR_W'(ORIGIN_X);
      pos_y_q     <= SCR_H'(ORIGIN_Y);
      sel_valid_q <= 1'b0;
      sel_col_q   <= '0;
      sel_row_q   <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      sel_valid_q <= sel_valid_d;
      sel_col_q   <= sel_col_d;
      sel_row_q   <= sel_row_d;
    end
  end

  assign cur_pos_x   = pos_x_q;
  assign cur_pos_y   = pos_y_q;
  assign cur_width_x = SCR_W'(CELL_W);
  assign cur_width_y = SCR_H'(CELL_H);
  assign cur_col     = col_q;
  assign cur_row     = row_q;
  assign sel_valid   = sel_valid_q;
  assign sel_col     = sel_col_q;
  assign sel_row     = sel_row_q;

endmodule

// File: tb/tb_board_cursor_ctrl.sv
// Scoreboard bench for board_cursor_ctrl with default parameters (8x8, 64x60 cells, origin 64,0).
module tb_board_cursor_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        en = 1'b1;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic        btn_sel = 1'b0;
  logic        sel_ready = 1'b0;
  logic [10:0] cur_pos_x, cur_width_x;
  logic [9:0]  cur_pos_y, cur_width_y;
  logic [2:0]  cur_col, cur_row, sel_col, sel_row;
  logic        sel_valid;

  typedef struct {
    string name;
    int    col, row, pos_x, pos_y, sv, sc, sr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  board_cursor_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .en          (en),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_sel     (btn_sel),
    .sel_ready   (sel_ready),
    .cur_pos_x   (cur_pos_x),
    .cur_pos_y   (cur_pos_y),
    .cur_width_x (cur_width_x),
    .cur_width_y (cur_width_y),
    .cur_col     (cur_col),
    .cur_row     (cur_row),
    .sel_valid   (sel_valid),
    .sel_col     (sel_col),
    .sel_row     (sel_row)
  );

  // 10 ns pixel clock.
  always #5 clk = ~clk;

  // Monitor: pop one expected snapshot per falling edge and compare against the DUT outputs.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (int'(cur_col) == e.col && int'(cur_row) == e.row &&
          int'(cur_pos_x) == e.pos_x && int'(cur_pos_y) == e.pos_y &&
          int'(cur_width_x) == 64 && int'(cur_width_y) == 60 &&
          int'(sel_valid) == e.sv && int'(sel_col) == e.sc && int'(sel_row) == e.sr)
        n_pass++;
      else
        $display("[TB] FAIL %s: got col=%0d row=%0d x=%0d y=%0d w=%0d h=%0d sv=%0d sc=%0d sr=%0d, want col=%0d row=%0d x=%0d y=%0d w=64 h=60 sv=%0d sc=%0d sr=%0d",
                 e.name, cur_col, cur_row, cur_pos_x, cur_pos_y, cur_width_x, cur_width_y,
                 sel_valid, sel_col, sel_row, e.col, e.row, e.pos_x, e.pos_y, e.sv, e.sc, e.sr);
    end
  end

  // Queue an expected snapshot; the pixel position follows from the cell geometry.
  task automatic checkOutput(input string name, input int col, input int row,
                             input int sv, input int sc, input int sr);
    exp_t e;
    e.name  = name;
    e.col   = col;
    e.row   = row;
    e.pos_x = 64 + col * 64;
    e.pos_y = row * 60;
    e.sv    = sv;
    e.sc    = sc;
    e.sr    = sr;
    exp_q.push_back(e);
  endtask

  // Issue n frame ticks, each a single-cycle pulse; returns just after the edge that consumed the last one.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk); #1 frame_tick = 1'b1;
      @(posedge clk); #1 frame_tick = 1'b0;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    $display("[TB] start");
    cycles(2);
    checkOutput("reset", 0, 0, 0, 0, 0);
    cycles(1);
    rst_n = 1'b1;

    btn_right = 1'b1;
    applyStimulus(1);   checkOutput("right_tick1", 1, 0, 0, 0, 0);
    applyStimulus(29);  checkOutput("right_tick30", 1, 0, 0, 0, 0);
    applyStimulus(1);   checkOutput("right_tick31", 2, 0, 0, 0, 0);
    applyStimulus(5);   checkOutput("right_tick36", 2, 0, 0, 0, 0);
    applyStimulus(1);   checkOutput("right_tick37", 3, 0, 0, 0, 0);
    applyStimulus(5);
    applyStimulus(1);   checkOutput("right_tick43", 4, 0, 0, 0, 0);
    btn_right = 1'b0;
    applyStimulus(8);   checkOutput("release", 4, 0, 0, 0, 0);

    for (int i = 0; i < 3; i++) begin
      btn_right = 1'b1; applyStimulus(1);
      btn_right = 1'b0; applyStimulus(1);
    end
    checkOutput("reach_col7", 7, 0, 0, 0, 0);
    btn_right = 1'b1;
    applyStimulus(40);  checkOutput("clamp_right", 7, 0, 0, 0, 0);
    btn_right = 1'b0;   applyStimulus(1);

    btn_up = 1'b1;
    applyStimulus(35);  checkOutput("clamp_up", 7, 0, 0, 0, 0);
    btn_up = 1'b0;      applyStimulus(1);

    btn_left = 1'b1; btn_up = 1'b1;
    applyStimulus(3);   checkOutput("two_buttons", 7, 0, 0, 0, 0);
    btn_left = 1'b0; btn_up = 1'b0;
    applyStimulus(1);

    btn_down = 1'b1;
    applyStimulus(1);   checkOutput("down_once", 7, 1, 0, 0, 0);
    btn_down = 1'b0; btn_left = 1'b1;
    applyStimulus(1);   checkOutput("dir_change_nomove", 7, 1, 0, 0, 0);
    applyStimulus(1);   checkOutput("dir_change_move", 6, 1, 0, 0, 0);
    btn_left = 1'b0;    applyStimulus(1);

    btn_down = 1'b1; applyStimulus(1);
    btn_down = 1'b0; applyStimulus(1);
    for (int i = 0; i < 3; i++) begin
      btn_left = 1'b1; applyStimulus(1);
      btn_left = 1'b0; applyStimulus(1);
    end
    checkOutput("at_3_2", 3, 2, 0, 0, 0);

    btn_sel = 1'b1;
    cycles(1);          checkOutput("sel_set", 3, 2, 1, 3, 2);
    cycles(5);          checkOutput("sel_hold", 3, 2, 1, 3, 2);
    btn_sel = 1'b0; cycles(1);
    btn_sel = 1'b1; btn_down = 1'b1;
    applyStimulus(2);   checkOutput("sel_blocks_move", 3, 2, 1, 3, 2);
    btn_down = 1'b0;
    sel_ready = 1'b1;
    cycles(1);          checkOutput("sel_clear", 3, 2, 0, 3, 2);
    sel_ready = 1'b0; btn_sel = 1'b0;
    cycles(1);

    btn_sel = 1'b1; cycles(1);
    btn_sel = 1'b0; cycles(1);
    btn_sel = 1'b1; sel_ready = 1'b1;
    cycles(1);          checkOutput("clear_beats_edge", 3, 2, 0, 3, 2);
    sel_ready = 1'b0;
    cycles(1);          checkOutput("edge_dropped", 3, 2, 0, 3, 2);
    btn_sel = 1'b0;
    cycles(1);

    btn_down = 1'b1;
    applyStimulus(1);   checkOutput("down_to_r3", 3, 3, 0, 3, 2);
    applyStimulus(30);  checkOutput("repeat_r4", 3, 4, 0, 3, 2);
    btn_sel = 1'b1;
    cycles(1);
    rst_n = 1'b0;
    checkOutput("async_reset", 0, 0, 0, 0, 0);
    cycles(2);
    btn_sel = 1'b0; btn_down = 1'b0;
    rst_n = 1'b1;
    cycles(2);          checkOutput("after_reset", 0, 0, 0, 0, 0);

    en = 1'b0; btn_right = 1'b1;
    applyStimulus(5);   checkOutput("en_off_nomove", 0, 0, 0, 0, 0);
    btn_sel = 1'b1;
    cycles(2);          checkOutput("en_off_nosel", 0, 0, 0, 0, 0);
    btn_sel = 1'b0;
    en = 1'b1;
    applyStimulus(1);   checkOutput("en_on_move", 1, 0, 0, 0, 0);
    btn_right = 1'b0;

    cycles(3);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("[TB] FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/board_cursor_ctrl.md
Name: board_cursor_ctrl

Overview:
Sequences the sprite-overlay compositor for the board cursor. Converts direction buttons into cell-by-cell cursor moves on a COLS x ROWS board. Moves are applied only at frame boundaries, with hold-to-autorepeat. Drives the compositor's object position and size inputs, and issues a select handshake to game logic.

Parameters:
COLS, 8, board columns (2..64)
ROWS, 8, board rows (2..64)
CELL_W, 64, cell width in pixels
CELL_H, 60, cell height in pixels
ORIGIN_X, 64, x pixel of cell (0,0)
ORIGIN_Y, 0, y pixel of cell (0,0)
REPEAT_DELAY, 30, frames a direction is held before the first autorepeat (>=1)
REPEAT_RATE, 6, frames between autorepeat moves (>=1)

Ports:
clk  in  1  pixel-domain clock
rst_n  in  1  asynchronous active-low reset
frame_tick  in  1  single-cycle pulse at start of vertical blank
en  in  1  cursor enable
btn_up, btn_down, btn_left, btn_right  in  1 each  level, already synchronised to clk
btn_sel  in  1  level, already synchronised to clk
sel_ready  in  1  game logic accepts selection
cur_pos_x  out  11  cursor left pixel
cur_pos_y  out  10  cursor top pixel
cur_width_x  out  11  constant CELL_W
cur_width_y  out  10  constant CELL_H
cur_col  out  $clog2(COLS)  current column
cur_row  out  $clog2(ROWS)  current row
sel_valid  out  1  selection pending
sel_col  out  $clog2(COLS)  selected column
sel_row  out  $clog2(ROWS)  selected row

Behaviour:
- Reset (async, rst_n low) values:
  - cur_col = cur_row = 0
  - cur_pos_x = ORIGIN_X, cur_pos_y = ORIGIN_Y
  - sel_valid = 0, sel_col = sel_row = 0
  - FSM = IDLE, frame counter = 0, sel edge register = 0
  - Width outputs are constant at all times.
- Direction decode: exactly one of the four direction buttons high gives a valid direction. Zero or more than one high gives NONE.
- Direction is evaluated only on frame_tick cycles; button changes between ticks are ignored.
- FSM (all transitions on frame_tick only):
  - IDLE: dir != NONE -> apply move, latch dir, cnt = 0, go to DELAY.
  - DELAY:
    - dir != latched (including NONE) -> IDLE; no move this tick.
    - else if cnt == REPEAT_DELAY-1 -> move, cnt = 0, go to REPEAT.
    - else cnt++.
  - REPEAT: same as DELAY, using REPEAT_RATE; stays in REPEAT.
- Edge clamp:
  - A move past col 0 / COLS-1 / row 0 / ROWS-1 is suppressed; the position is unchanged, with no wrap.
  - The FSM still advances as if the move had occurred.
- Position registers:
  - cur_pos_x = ORIGIN_X + cur_col*CELL_W; cur_pos_y = ORIGIN_Y + cur_row*CELL_H.
  - Both are registered and computed from the next col/row, so they update in the same cycle as cur_col/cur_row: one cycle after the frame_tick edge.
  - They are never mid-frame, so there is no tearing.
  - Elaboration check: ORIGIN_X + COLS*CELL_W <= 2048 and ORIGIN_Y + ROWS*CELL_H <= 1024.
- Select:
  - Rising edge of btn_sel while sel_valid = 0 and en = 1 -> next cycle sel_valid = 1, with sel_col/sel_row latched from cur_col/cur_row.
  - sel_valid && sel_ready -> sel_valid = 0 next cycle; sel_col/sel_row hold their values.
  - sel_valid and sel_ready high in the same cycle as a new rising edge -> the clear wins; the edge is dropped.
  - Rising edges while sel_valid = 1 are dropped.
- While sel_valid = 1: FSM forced to IDLE and no moves occur.
- en = 0:
  - FSM forced to IDLE, cnt = 0, no moves, select edges ignored.
  - A pending sel_valid still completes its handshake.
- Reset mid-hold or mid-handshake: everything returns to reset values asynchronously; no move or selection survives.

Decomposition:
- board_pkg holds:
  - dir_t enum: NONE, UP, DOWN, LEFT, RIGHT
  - cur_state_t enum: IDLE, DELAY, REPEAT
  - screen constants SCR_W = 11 bits, SCR_H = 10 bits
- Sub-module rise_detect: 1-bit registered rising-edge detector with clk/rst_n, used for btn_sel.
- FSM, counter, clamp and position arithmetic stay in board_cursor_ctrl.

Test Plan:
- Reset -> pos (64,0), col/row 0, sel_valid 0. Hold btn_right across 1 frame_tick -> col 1, pos_x 128 on the next clk.
- Hold btn_right for 30+6+6 ticks -> moves at tick 1, tick 31, then ticks 37 and 43, giving col 4, pos_x 320. Release -> no further moves.
- At col 7, btn_right held for 40 ticks -> col stays 7, pos_x stays 512. At row 0, btn_up -> row stays 0.
- btn_left and btn_up both high -> no move. Direction changed mid-DELAY -> no move at that tick; the new direction moves on the following tick.
- btn_sel pulse at (3,2) with sel_ready = 0 for 5 cycles -> sel_valid held, sel_col 3, sel_row 2. A second btn_sel is dropped and btn_down does not move. sel_ready = 1 -> sel_valid 0 next cycle.
- rst_n low while in REPEAT with sel pending -> immediate reset values. en = 0 with buttons held -> no moves.
